// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared state encoding, error codes and opcode constants for the loader
package mips32_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_WORD   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  // Error codes reported on err
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  // Halt opcode, used by program images to stop the processor
  localparam logic [5:0] HLT_OPCODE = 6'b111111;

endpackage

// File: rtl/mips32_word_assembler.sv
// rtl/mips32_word_assembler.sv - packs four big-endian stream bytes into a 32-bit word
module mips32_word_assembler (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] sr_q, sr_d;

  // The finished word includes the byte being accepted this cycle so the top
  // can register it into mem_wdata on the same edge that ends the word.
  assign word       = {sr_q[23:0], byte_in};
  assign word_ready = en && !clr && (idx_q == 2'd3);

  // Next-state for byte index and shift register; clr wins over en
  always_comb begin
    idx_d = idx_q;
    sr_d  = sr_q;
    if (clr) begin
      idx_d = 2'd0;
      sr_d  = 32'd0;
    end else if (en) begin
      idx_d = idx_q + 2'd1;
      sr_d  = {sr_q[23:0], byte_in};
    end
  end

  // Byte index and shift register flops
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 2'd0;
      sr_q  <= 32'd0;
    end else begin
      idx_q <= idx_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/mips32_prog_loader.sv
// rtl/mips32_prog_loader.sv - framed byte-stream loader writing program words into memory
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [16:0]       MAX_N = 17'(MAX_WORDS);

  state_t              state_q, state_d;
  logic [7:0]          xor_q, xor_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic [1:0]          err_q, err_d;

  logic                accept;
  logic                asm_en;
  logic                asm_clr;
  logic [31:0]         asm_word;
  logic                asm_ready;
  logic [15:0]         n_words;
  logic [15:0]         next_count;

  assign s_ready    = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_WORD)   || (state_q == S_CSUM);
  assign accept     = s_valid && s_ready;
  assign asm_en     = accept && (state_q == S_WORD);
  assign asm_clr    = (state_q != S_WORD);
  assign n_words    = {len_q[15:8], s_data};
  assign next_count = 16'(words_loaded_q) + 16'd1;

  mips32_word_assembler u_asm (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .clr        (asm_clr),
    .en         (asm_en),
    .byte_in    (s_data),
    .word       (asm_word),
    .word_ready (asm_ready)
  );

  // Frame FSM: next state, running checksum, write strobe and status outputs
  always_comb begin
    state_d        = state_q;
    xor_d          = xor_q;
    len_d          = len_q;
    words_loaded_d = words_loaded_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_hold_d     = cpu_hold_q;
    done_d         = done_q;
    err_d          = err_q;
    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = s_data;
          xor_d       = xor_q ^ s_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = s_data;
          xor_d      = xor_q ^ s_data;
          if ({1'b0, n_words} > MAX_N) begin
            state_d = S_ERROR;
            err_d   = ERR_LEN;
          end else if (n_words == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_WORD;
          end
        end
      end
      S_WORD: begin
        if (accept) begin
          xor_d = xor_q ^ s_data;
          if (asm_ready) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_wdata_d = asm_word;
            mem_addr_d  = BASE + words_loaded_q[ADDR_W-1:0];
          end
        end
      end
      S_WRITE: begin
        words_loaded_d = words_loaded_q + 1'b1;
        state_d        = (next_count == len_q) ? S_CSUM : S_WORD;
      end
      S_CSUM: begin
        if (accept) begin
          if (s_data == xor_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = ERR_CSUM;
          end
        end
      end
      default: begin
        // IDLE, DONE and ERROR all re-arm on start
        if (start) begin
          state_d        = S_LEN_HI;
          done_d         = 1'b0;
          cpu_hold_d     = 1'b1;
          err_d          = ERR_NONE;
          words_loaded_d = '0;
          xor_d          = 8'd0;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_LEN_HI;
      xor_q          <= 8'd0;
      len_q          <= 16'd0;
      words_loaded_q <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= BASE;
      mem_wdata_q    <= 32'd0;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      err_q          <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      xor_q          <= xor_d;
      len_q          <= len_d;
      words_loaded_q <= words_loaded_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_loaded_q;

endmodule
